// File: rtl/change_dispenser.sv
// Change dispenser: latches vend / coin-return requests, services them in
// priority order through a VEND / EJECT / SENSE sequencer, and keeps a
// per-tube coin count that is refilled by pulses and decremented when the
// chute sensor confirms an ejected coin.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int TIMEOUT      = 16,
    parameter int STOCK_INIT   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dispense,
    input  logic       return_one_rupee,
    input  logic       return_two_rupee,
    input  logic       refill_one,
    input  logic       refill_two,
    input  logic       coin_sensed,
    output logic       product_motor,
    output logic       eject_one,
    output logic       eject_two,
    output logic [3:0] stock_one,
    output logic [3:0] stock_two,
    output logic       busy,
    output logic       fault,
    output logic       overrun
);

    localparam int MAX_PM = (PULSE_CYCLES > MOTOR_CYCLES) ? PULSE_CYCLES : MOTOR_CYCLES;
    localparam int MAXC   = (TIMEOUT > MAX_PM) ? TIMEOUT : MAX_PM;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, VEND, EJECT, SENSE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cur_two;   // tube of the coin currently in flight
    logic          extra;     // a second ₹1 coin is still planned
    logic          pend_prod;
    logic          pend_two;
    logic          pend_one;
    logic          start_prod;
    logic          start_two;
    logic          start_one;
    logic          dec_one;
    logic          dec_two;

    // Service-start strobes and sensor-confirmed decrements
    always_comb begin
        start_prod = (state == IDLE) && pend_prod;
        start_two  = (state == IDLE) && !pend_prod && pend_two;
        start_one  = (state == IDLE) && !pend_prod && !pend_two && pend_one;
        dec_one    = (state == SENSE) && coin_sensed && !cur_two;
        dec_two    = (state == SENSE) && coin_sensed && cur_two;
    end

    assign busy = (state != IDLE) || pend_prod || pend_two || pend_one;

    // Request latching; a request hitting an already-set flag is dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_prod <= 1'b0;
            pend_two  <= 1'b0;
            pend_one  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pend_prod <= (pend_prod && !start_prod) || (dispense && !pend_prod);
            pend_two  <= (pend_two && !start_two) || (return_two_rupee && !pend_two);
            pend_one  <= (pend_one && !start_one) || (return_one_rupee && !pend_one);
            if ((dispense && pend_prod) || (return_two_rupee && pend_two) ||
                (return_one_rupee && pend_one))
                overrun <= 1'b1;
        end
    end

    // Tube counts: saturating refill, sensed decrement, coincident pair cancels
    always_ff @(posedge clk) begin
        if (!reset) begin
            stock_one <= 4'(STOCK_INIT);
            stock_two <= 4'(STOCK_INIT);
        end else begin
            if (refill_one && !dec_one) begin
                if (stock_one != 4'hF) stock_one <= stock_one + 4'd1;
            end else if (dec_one && !refill_one && stock_one != 4'd0) begin
                stock_one <= stock_one - 4'd1;
            end
            if (refill_two && !dec_two) begin
                if (stock_two != 4'hF) stock_two <= stock_two + 4'd1;
            end else if (dec_two && !refill_two && stock_two != 4'd0) begin
                stock_two <= stock_two - 4'd1;
            end
        end
    end

    // Sequencer with registered motor / solenoid drives and sticky fault
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_two       <= 1'b0;
            extra         <= 1'b0;
            product_motor <= 1'b0;
            eject_one     <= 1'b0;
            eject_two     <= 1'b0;
            fault         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_prod) begin
                        state         <= VEND;
                        product_motor <= 1'b1;
                        cnt           <= CW'(MOTOR_CYCLES - 1);
                    end else if (pend_two) begin
                        if (stock_two != 4'd0) begin
                            state     <= EJECT;
                            eject_two <= 1'b1;
                            cur_two   <= 1'b1;
                            extra     <= 1'b0;
                            cnt       <= CW'(PULSE_CYCLES - 1);
                        end else if (stock_one >= 4'd2) begin
                            state     <= EJECT;
                            eject_one <= 1'b1;
                            cur_two   <= 1'b0;
                            extra     <= 1'b1;
                            cnt       <= CW'(PULSE_CYCLES - 1);
                        end else begin
                            fault <= 1'b1;
                        end
                    end else if (pend_one) begin
                        if (stock_one != 4'd0) begin
                            state     <= EJECT;
                            eject_one <= 1'b1;
                            cur_two   <= 1'b0;
                            extra     <= 1'b0;
                            cnt       <= CW'(PULSE_CYCLES - 1);
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (cnt == '0) begin
                        state         <= IDLE;
                        product_motor <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EJECT: begin
                    if (cnt == '0) begin
                        state     <= SENSE;
                        eject_one <= 1'b0;
                        eject_two <= 1'b0;
                        cnt       <= CW'(TIMEOUT - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SENSE: begin
                    if (coin_sensed) begin
                        if (extra) begin
                            state <= EJECT;
                            extra <= 1'b0;
                            cnt   <= CW'(PULSE_CYCLES - 1);
                            if (cur_two) eject_two <= 1'b1;
                            else         eject_one <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == '0) begin
                        fault <= 1'b1;
                        extra <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized transactions
// checked against a transaction-level model of tube counts and flags.
module tb_change_dispenser;

    localparam int PULSE = 4;
    localparam int MOTOR = 8;
    localparam int TMO   = 16;
    localparam int SINIT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dispense = 1'b0;
    logic       return_one_rupee = 1'b0;
    logic       return_two_rupee = 1'b0;
    logic       refill_one = 1'b0;
    logic       refill_two = 1'b0;
    logic       coin_sensed = 1'b0;
    logic       product_motor;
    logic       eject_one;
    logic       eject_two;
    logic [3:0] stock_one;
    logic [3:0] stock_two;
    logic       busy;
    logic       fault;
    logic       overrun;

    always #5 clk = ~clk;

    change_dispenser #(
        .PULSE_CYCLES(PULSE),
        .MOTOR_CYCLES(MOTOR),
        .TIMEOUT(TMO),
        .STOCK_INIT(SINIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dispense(dispense),
        .return_one_rupee(return_one_rupee),
        .return_two_rupee(return_two_rupee),
        .refill_one(refill_one),
        .refill_two(refill_two),
        .coin_sensed(coin_sensed),
        .product_motor(product_motor),
        .eject_one(eject_one),
        .eject_two(eject_two),
        .stock_one(stock_one),
        .stock_two(stock_two),
        .busy(busy),
        .fault(fault),
        .overrun(overrun)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    int s1_m;
    int s2_m;
    bit fault_m;
    bit ovr_m;

    // output pulse monitor (counts pulses and high cycles)
    int   e1_pulses = 0, e2_pulses = 0, m_pulses = 0;
    int   e1_cyc = 0, e2_cyc = 0, m_cyc = 0;
    logic pe1 = 1'b0, pe2 = 1'b0, pm = 1'b0;
    always @(negedge clk) begin
        if (eject_one) e1_cyc++;
        if (eject_two) e2_cyc++;
        if (product_motor) m_cyc++;
        if (eject_one && !pe1) e1_pulses++;
        if (eject_two && !pe2) e2_pulses++;
        if (product_motor && !pm) m_pulses++;
        pe1 = eject_one;
        pe2 = eject_two;
        pm  = product_motor;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Runs until the DUT is idle, answering each finished eject pulse with a
    // coin_sensed pulse d cycles later when respond is set.
    task automatic run_until_idle(input bit respond, input int d, input bit coinc,
                                  output int fall_c, output int fault_c,
                                  output int first_ej_c, output int last_m_c);
        int cd;
        bit prev_e, cur_e, prev_f, done;
        cd = -1; prev_e = 1'b0; done = 1'b0;
        fall_c = -1; fault_c = -1; first_ej_c = -1; last_m_c = -1;
        prev_f = fault;
        for (int c = 0; c < 400 && !done; c++) begin
            coin_sensed = 1'b0;
            refill_one  = 1'b0;
            if (cd == 0) begin
                coin_sensed = 1'b1;
                refill_one  = coinc;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            tick();
            cur_e = eject_one | eject_two;
            if (cur_e && first_ej_c < 0) first_ej_c = c;
            if (product_motor) last_m_c = c;
            if (prev_e && !cur_e) begin
                fall_c = c;
                if (respond) cd = d;
            end
            if (fault && !prev_f && fault_c < 0) fault_c = c;
            prev_e = cur_e;
            prev_f = fault;
            if (!busy) done = 1'b1;
        end
        coin_sensed = 1'b0;
        refill_one  = 1'b0;
        check("idle_within_budget", done, 1);
    endtask

    // kind: 0 dispense, 1 return ₹2, 2 return ₹1
    task automatic do_txn(input int kind, input bit respond, input int d, input bit coinc,
                          output int fall_c, output int fault_c);
        int b_e1p, b_e2p, b_mp, b_e1c, b_e2c, b_mc;
        int x_e1, x_e2, x_m, fe, lm;
        b_e1p = e1_pulses; b_e2p = e2_pulses; b_mp = m_pulses;
        b_e1c = e1_cyc;    b_e2c = e2_cyc;    b_mc = m_cyc;
        x_e1 = 0; x_e2 = 0; x_m = 0;
        case (kind)
            0: x_m = 1;
            1: begin
                if (s2_m >= 1) begin
                    x_e2 = 1;
                    if (respond) s2_m--; else fault_m = 1'b1;
                end else if (s1_m >= 2) begin
                    if (respond) begin x_e1 = 2; s1_m -= 2; end
                    else begin x_e1 = 1; fault_m = 1'b1; end
                end else begin
                    fault_m = 1'b1;
                end
            end
            default: begin
                if (s1_m >= 1) begin
                    x_e1 = 1;
                    if (!respond) fault_m = 1'b1;
                    else if (!coinc) s1_m--;
                end else begin
                    fault_m = 1'b1;
                end
            end
        endcase
        case (kind)
            0:       dispense = 1'b1;
            1:       return_two_rupee = 1'b1;
            default: return_one_rupee = 1'b1;
        endcase
        tick();
        dispense = 1'b0; return_two_rupee = 1'b0; return_one_rupee = 1'b0;
        run_until_idle(respond, d, coinc, fall_c, fault_c, fe, lm);
        check("txn_e1_pulses", e1_pulses - b_e1p, x_e1);
        check("txn_e2_pulses", e2_pulses - b_e2p, x_e2);
        check("txn_motor_pulses", m_pulses - b_mp, x_m);
        check("txn_e1_cycles", e1_cyc - b_e1c, x_e1 * PULSE);
        check("txn_e2_cycles", e2_cyc - b_e2c, x_e2 * PULSE);
        check("txn_motor_cycles", m_cyc - b_mc, x_m * MOTOR);
        check("txn_stock_one", stock_one, s1_m);
        check("txn_stock_two", stock_two, s2_m);
        check("txn_fault", fault, fault_m);
    endtask

    task automatic do_refill(input bit two);
        if (two) begin
            refill_two = 1'b1;
            if (s2_m < 15) s2_m++;
        end else begin
            refill_one = 1'b1;
            if (s1_m < 15) s1_m++;
        end
        tick();
        refill_one = 1'b0; refill_two = 1'b0;
        check("refill_stock_one", stock_one, s1_m);
        check("refill_stock_two", stock_two, s2_m);
    endtask

    initial begin
        int fall_c, fault_c, first_ej, last_m;
        int b_e2p, b_mp, s1_before;
        bit seen;

        // reset state
        reset = 1'b0;
        repeat (2) tick();
        check("rst_motor", product_motor, 0);
        check("rst_eject_one", eject_one, 0);
        check("rst_eject_two", eject_two, 0);
        check("rst_stock_one", stock_one, SINIT);
        check("rst_stock_two", stock_two, SINIT);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        s1_m = SINIT; s2_m = SINIT; fault_m = 1'b0; ovr_m = 1'b0;
        tick();

        // dispense at cycle 0: motor high cycles 2..9, idle by cycle 10
        dispense = 1'b1;
        tick();
        dispense = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            check("vend_motor_window", product_motor, (k >= 2 && k <= 9));
            if (k == 10) check("vend_busy_low", busy, 0);
            tick();
        end

        // dispense + return ₹2 together, second ₹2 request while pending
        b_e2p = e2_pulses; b_mp = m_pulses;
        dispense = 1'b1; return_two_rupee = 1'b1;
        tick();
        dispense = 1'b0;
        tick();
        return_two_rupee = 1'b0;
        s2_m--; ovr_m = 1'b1;
        run_until_idle(1'b1, 1, 1'b0, fall_c, fault_c, first_ej, last_m);
        check("prio_overrun", overrun, ovr_m);
        check("prio_two_coins", e2_pulses - b_e2p, 1);
        check("prio_motor_pulses", m_pulses - b_mp, 1);
        check("prio_motor_first", (first_ej > last_m) && (last_m >= 0), 1);
        check("prio_stock_two", stock_two, s2_m);

        // refill saturation, and refill coincident with a sensed decrement
        while (s2_m < 15) do_refill(1'b1);
        do_refill(1'b1);
        check("refill_sat_two", stock_two, 15);
        s1_before = s1_m;
        do_txn(2, 1'b1, 1, 1'b1, fall_c, fault_c);
        check("coinc_stock_one", stock_one, s1_before);

        // drain to stock_two=0, stock_one=3
        repeat (15) do_txn(1, 1'b1, 0, 1'b0, fall_c, fault_c);
        check("drain_stock_two", stock_two, 0);
        while (s1_m > 3) do_txn(2, 1'b1, 0, 1'b0, fall_c, fault_c);

        // ₹2 with no ₹2 coins: two ₹1 coins, sensor 2 cycles after each pulse
        do_txn(1, 1'b1, 2, 1'b0, fall_c, fault_c);
        check("two_as_ones_stock_one", stock_one, 1);
        check("two_as_ones_fault", fault, 0);

        // ₹1 with no sensor response: fault after 16 SENSE cycles
        do_txn(2, 1'b0, 0, 1'b0, fall_c, fault_c);
        check("timeout_fault_delay", fault_c - fall_c, TMO);
        check("timeout_stock_one", stock_one, 1);

        // reset mid-EJECT
        do_refill(1'b1);
        return_two_rupee = 1'b1;
        tick();
        return_two_rupee = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (eject_two) seen = 1'b1;
        end
        check("midrst_eject_seen", seen, 1);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_eject_two", eject_two, 0);
        check("midrst_busy", busy, 0);
        check("midrst_stock_one", stock_one, SINIT);
        check("midrst_stock_two", stock_two, SINIT);
        check("midrst_fault", fault, 0);
        check("midrst_overrun", overrun, 0);
        reset = 1'b1;
        s1_m = SINIT; s2_m = SINIT; fault_m = 1'b0; ovr_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("postrst_no_eject", eject_two | eject_one | product_motor, 0);
        end

        // randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            int kind, d;
            bit resp;
            if ($urandom_range(0, 3) == 0) do_refill($urandom_range(0, 1) == 1);
            kind = int'($urandom_range(0, 2));
            resp = ($urandom_range(0, 4) != 0);
            d    = int'($urandom_range(0, 6));
            do_txn(kind, resp, d, 1'b0, fall_c, fault_c);
        end
        check("final_overrun", overrun, ovr_m);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4: ejector solenoid on-time, in cycles.
REQ-002 SHALL have parameter MOTOR_CYCLES, default 8: product motor on-time, in cycles.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for coin_sensed after an eject pulse ends.
REQ-004 SHALL have parameter STOCK_INIT, default 10: coins per tube after reset, range 0..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port dispense, input, 1 bit: one-cycle product vend request.
REQ-008 SHALL have port return_one_rupee, input, 1 bit: one-cycle request to return ₹1.
REQ-009 SHALL have port return_two_rupee, input, 1 bit: one-cycle request to return ₹2.
REQ-010 SHALL have ports refill_one and refill_two, inputs, 1 bit each: one-cycle pulse, each adding one coin to its tube.
REQ-011 SHALL have port coin_sensed, input, 1 bit: one-cycle pulse from the chute sensor when an ejected coin passes.
REQ-012 SHALL have port product_motor, output, 1 bit: drives the vend motor.
REQ-013 SHALL have ports eject_one and eject_two, outputs, 1 bit each: drive the solenoids of the ₹1 and ₹2 tubes.
REQ-014 SHALL have ports stock_one and stock_two, outputs, 4 bits each: current coin count of each tube.
REQ-015 SHALL have port busy, output, 1 bit: high when state is not IDLE or any request is pending.
REQ-016 SHALL have ports fault and overrun, outputs, 1 bit each: sticky error flags.

Function
REQ-017 SHALL latch each request input into its own pending flag (pend_prod, pend_two, pend_one) at the edge where that input is sampled high.
REQ-018 SHALL set overrun, and drop the new request, when a request arrives while its pending flag is already set.
REQ-019 SHALL use FSM states IDLE, VEND, EJECT, SENSE, with outputs decoded from registered state.
REQ-020 SHALL, in IDLE, service pending requests in priority order pend_prod, then pend_two, then pend_one, clearing a request's flag at the edge where service starts.
REQ-021 SHALL enter VEND from IDLE at the edge after pend_prod is set, hold product_motor high for exactly MOTOR_CYCLES cycles, then return to IDLE.
REQ-022 SHALL run each coin through EJECT (eject_one or eject_two high for exactly PULSE_CYCLES cycles) and then SENSE.
REQ-023 SHALL plan ₹2 service as one ₹2 coin if stock_two>=1, else two ₹1 coins if stock_one>=2, else no ejection with fault set.
REQ-024 SHALL plan ₹1 service as one ₹1 coin if stock_one>=1, else no ejection with fault set.
REQ-025 SHALL, in SENSE, decrement the ejected tube's stock when coin_sensed is high, then start the next planned coin in EJECT or return to IDLE.
REQ-026 SHALL, on SENSE timeout (TIMEOUT cycles with no coin_sensed), set fault, leave stock unchanged, abandon the remaining planned coins, and return to IDLE.
REQ-027 SHALL ignore coin_sensed in every state except SENSE.
REQ-028 SHALL saturate stock at 15 on refill, ignoring refills at 15.
REQ-029 SHALL leave stock unchanged when a refill and a decrement of the same tube occur in the same cycle.
REQ-030 SHALL keep fault and overrun set until reset.
REQ-031 SHALL continue servicing requests when fault is set.

Reset
REQ-032 SHALL, at any rising clk edge with reset=0 (including mid-operation), force state=IDLE, clear all pending flags, set product_motor=eject_one=eject_two=busy=fault=overrun=0, and set stock_one=stock_two=STOCK_INIT.
REQ-033 SHALL make no ejector or motor pulse from before reset continue after reset.

Verification
REQ-034 Bench SHALL check: dispense pulse at cycle 0 -> product_motor high for cycles 2-9, busy low by cycle 10.
REQ-035 Bench SHALL check: return_two_rupee with stock_two=0, stock_one=3, and coin_sensed 2 cycles after each pulse -> two eject_one pulses of 4 cycles each, stock_one=1, fault=0.
REQ-036 Bench SHALL check: return_one_rupee with coin_sensed never asserted -> one eject_one pulse, fault=1 after 16 SENSE cycles, stock_one unchanged.
REQ-037 Bench SHALL check: dispense and return_two_rupee in the same cycle, followed by a second return_two_rupee while pending -> motor runs before the ejector, overrun=1, exactly one ₹2 coin ejected.
REQ-038 Bench SHALL check: refill_two with stock_two=15, then refill_one coincident with a coin_sensed decrement of tube one -> stock_two stays 15, stock_one unchanged.
REQ-039 Bench SHALL check: reset=0 asserted mid-EJECT -> next cycle eject_two=0, state IDLE, stock_one=stock_two=10.
